frame_uart_dumper: RTL and testbench

Serializes one downsampled frame from the downsample buffer's read port onto the debug UART when the dump button is pressed. It sits between the downsample block's read port and the UART transmitter, all in the 12 MHz system domain. It debounces the trigger, walks the buffer in raster order and emits a framed byte stream: header, pixel bytes, then a checksum. The UART byte handshake is paced by a holdoff counter.

---
 rtl/frame_uart_dumper.sv | 205 ++++++++++++++++++++
 tb/tb_frame_uart_dumper.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_uart_dumper.sv
// Dumps one downsampled frame over the debug UART: header, raster-order pixel bytes, checksum.
// Trigger is synchronised and debounced; every byte waits for a saturated idle holdoff.
module frame_uart_dumper #(
  parameter int unsigned WIDTH         = 40,
  parameter int unsigned HEIGHT        = 30,
  parameter int unsigned XW            = 6,
  parameter int unsigned YW            = 5,
  parameter int unsigned HOLDOFF_BITS  = 13,
  parameter int unsigned DEBOUNCE_BITS = 14,
  parameter logic [7:0]  SYNC0         = 8'hA5,
  parameter logic [7:0]  SYNC1         = 8'h5A
) (
  input  logic          clk12_i,
  input  logic          areset_i,
  input  logic          trigger_i,
  output logic [XW-1:0] read_x_o,
  output logic [YW-1:0] read_y_o,
  input  logic [31:0]   read_q_i,
  input  logic          uart_busy_i,
  output logic          uart_write_o,
  output logic [7:0]    uart_data_o,
  output logic          busy_o,
  output logic          done_o
);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StFetch,
    StData,
    StCheck,
    StDone
  } state_e;

  state_e                   state_q;
  logic                     trig_q;
  logic [DEBOUNCE_BITS-1:0] deb_q, deb_d;
  logic [HOLDOFF_BITS-1:0]  hold_q, hold_d;
  logic [1:0]               idx_q;
  logic                     fetch_q;
  logic [31:0]              word_q;
  logic [7:0]               csum_q;
  logic [XW-1:0]            read_x_q;
  logic [YW-1:0]            read_y_q;
  logic                     write_q;
  logic [7:0]               data_q;
  logic                     busy_q;
  logic                     done_q;

  logic                     armed;
  logic                     send_ok;
  logic                     last_x;
  logic                     last_y;
  logic [7:0]               hdr_byte;
  logic [7:0]               data_byte;

  always_comb begin
    deb_d = deb_q;
    if (trig_q) begin
      deb_d = '0;
    end else if (!(&deb_q)) begin
      deb_d = deb_q + DEBOUNCE_BITS'(1);
    end

    // The write strobe itself clears holdoff, so back-to-back bytes keep the full gap.
    hold_d = hold_q;
    if (uart_busy_i || write_q) begin
      hold_d = '0;
    end else if (!(&hold_q)) begin
      hold_d = hold_q + HOLDOFF_BITS'(1);
    end
  end

  always_comb begin
    armed   = &deb_q;
    send_ok = (&hold_q) && !uart_busy_i && !write_q;
    last_x  = (read_x_q == XW'(WIDTH - 1));
    last_y  = (read_y_q == YW'(HEIGHT - 1));

    hdr_byte  = SYNC0;
    data_byte = word_q[31:24];
    unique case (idx_q)
      2'd0: begin
        hdr_byte  = SYNC0;
        data_byte = word_q[31:24];
      end
      2'd1: begin
        hdr_byte  = SYNC1;
        data_byte = word_q[23:16];
      end
      2'd2: begin
        hdr_byte  = 8'(WIDTH);
        data_byte = word_q[15:8];
      end
      default: begin
        hdr_byte  = 8'(HEIGHT);
        data_byte = word_q[7:0];
      end
    endcase
  end

  always_ff @(posedge clk12_i) begin
    if (areset_i) begin
      trig_q <= 1'b0;
      deb_q  <= '0;
      hold_q <= '0;
    end else begin
      trig_q <= trigger_i;
      deb_q  <= deb_d;
      hold_q <= hold_d;
    end
  end

  always_ff @(posedge clk12_i) begin
    if (areset_i) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      fetch_q  <= 1'b0;
      word_q   <= '0;
      csum_q   <= '0;
      read_x_q <= '0;
      read_y_q <= '0;
      write_q  <= 1'b0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trig_q && armed) begin
            busy_q   <= 1'b1;
            read_x_q <= '0;
            read_y_q <= '0;
            csum_q   <= '0;
            idx_q    <= 2'd0;
            state_q  <= StHeader;
          end
        end
        StHeader: begin
          if (send_ok) begin
            write_q <= 1'b1;
            data_q  <= hdr_byte;
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              fetch_q <= 1'b0;
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          // Second cycle at a stable address: buffer data is valid now.
          if (fetch_q) begin
            word_q  <= read_q_i;
            fetch_q <= 1'b0;
            state_q <= StData;
          end else begin
            fetch_q <= 1'b1;
          end
        end
        StData: begin
          if (send_ok) begin
            write_q <= 1'b1;
            data_q  <= data_byte;
            csum_q  <= csum_q + data_byte;
            idx_q   <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (last_x) begin
                read_x_q <= '0;
                read_y_q <= read_y_q + YW'(1);
              end else begin
                read_x_q <= read_x_q + XW'(1);
              end
              state_q <= (last_x && last_y) ? StCheck : StFetch;
            end
          end
        end
        StCheck: begin
          if (send_ok) begin
            write_q <= 1'b1;
            data_q  <= csum_q;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          read_x_q <= '0;
          read_y_q <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign read_x_o     = read_x_q;
  assign read_y_o     = read_y_q;
  assign uart_write_o = write_q;
  assign uart_data_o  = data_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_frame_uart_dumper.sv
// Directed/randomised bench for frame_uart_dumper: a UART and buffer model feed the DUT and the
// captured byte stream is compared against a frame-level expected stream.
module tb_frame_uart_dumper;

  localparam int W = 2;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        trigger = 1'b0;
  logic        hold_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        uart_busy;
  logic [31:0] rd_q = '0;
  logic [5:0]  read_x;
  logic [4:0]  read_y;
  logic        uart_write;
  logic [7:0]  uart_data;
  logic        busy;
  logic        done;

  int          n_asserts = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_write_cyc = -100;
  int          busy_seen_cyc = -100;
  int          busy_cnt = 0;
  int          busy_len = 10;
  bit          rand_busy = 1'b0;
  int          mode = 0;
  logic [7:0]  last_data = 8'h00;
  logic [7:0]  got[$];
  logic [7:0]  exp_q[$];
  logic [31:0] mem[H][W];

  always #5 clk = ~clk;
  assign uart_busy = hold_busy | model_busy;

  frame_uart_dumper #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .XW           (6),
    .YW           (5),
    .HOLDOFF_BITS (3),
    .DEBOUNCE_BITS(3),
    .SYNC0        (8'hA5),
    .SYNC1        (8'h5A)
  ) dut (
    .clk12_i     (clk),
    .areset_i    (areset),
    .trigger_i   (trigger),
    .read_x_o    (read_x),
    .read_y_o    (read_y),
    .read_q_i    (rd_q),
    .uart_busy_i (uart_busy),
    .uart_write_o(uart_write),
    .uart_data_o (uart_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Buffer read port: one cycle of latency from address to data.
  always @(posedge clk) begin
    if (mode == 1) rd_q <= 32'hFFFF_FFFF;
    else if (mode == 2) rd_q <= (read_x < 6'(W) && read_y < 5'(H)) ? mem[read_y[0]][read_x[0]] : '0;
    else rd_q <= {8'(read_y), 8'(read_x), 8'h11, 8'h22};
  end

  // Byte capture, pacing checks and UART busy model.
  always @(negedge clk) begin
    cyc++;
    if (uart_busy) busy_seen_cyc = cyc;
    if (!areset) begin
      if (uart_write) begin
        chk("gap_after_busy", 64'(cyc - busy_seen_cyc >= 8), 64'd1);
        chk("gap_after_write", 64'(cyc - last_write_cyc >= 8), 64'd1);
        got.push_back(uart_data);
        last_write_cyc = cyc;
        last_data      = uart_data;
      end else begin
        chk("data_hold", uart_data, last_data);
      end
      if (done) begin
        done_cnt++;
        chk("done_after_write", 64'(cyc - last_write_cyc), 64'd1);
      end
    end else begin
      last_data = 8'h00;
    end
    if (uart_write) busy_cnt = rand_busy ? int'($urandom_range(0, 12)) : busy_len;
    else if (busy_cnt > 0) busy_cnt--;
    model_busy = (busy_cnt != 0);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_at(input int x, input int y);
    if (mode == 1) return 32'hFFFF_FFFF;
    if (mode == 2) return mem[y][x];
    return {8'(y), 8'(x), 8'h11, 8'h22};
  endfunction

  task automatic build_expected();
    logic [31:0] w;
    int          sum;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'(W));
    exp_q.push_back(8'(H));
    sum = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        w = word_at(x, y);
        for (int b = 3; b >= 0; b--) begin
          exp_q.push_back(w[8*b +: 8]);
          sum = (sum + int'(w[8*b +: 8])) % 256;
        end
      end
    end
    exp_q.push_back(8'(sum));
  endtask

  task automatic check_dump(input string name);
    build_expected();
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), got[i], exp_q[i]);
  endtask

  task automatic start_dump(input string name);
    int k;
    got.delete();
    done_cnt = 0;
    trigger  = 1'b1;
    k = 0;
    while (!busy && k < 50) begin
      tick();
      k++;
    end
    chk({name, "_start"}, 64'(busy), 64'd1);
  endtask

  task automatic wait_bytes(input string name, input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 2000) begin
      tick();
      k++;
    end
    chk({name, "_bytes_reached"}, 64'(got.size() >= n), 64'd1);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 4000) begin
      tick();
      k++;
    end
    chk({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    tick();
    chk({name, "_idle_busy"}, 64'(busy), 64'd0);
    chk({name, "_idle_addr"}, {read_x, read_y}, 11'd0);
  endtask

  initial begin
    bit seen;
    int n0;

    // Reset, then idle with trigger low: every output stays zero.
    repeat (3) tick();
    areset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("reset_outputs", {uart_write, uart_data, busy, done, read_x, read_y}, '0);
    end
    chk("reset_no_bytes", 64'(got.size()), 64'd0);

    // Trigger held from reset never arms the block.
    areset  = 1'b1;
    trigger = 1'b1;
    repeat (2) tick();
    areset = 1'b0;
    seen   = 1'b0;
    repeat (30) begin
      tick();
      seen |= busy;
    end
    chk("held_trigger_no_start", 64'(seen), 64'd0);

    // Release, re-arm, then a full dump with a busy UART and a long stall mid-frame.
    trigger = 1'b0;
    repeat (10) tick();
    mode     = 0;
    busy_len = 10;
    start_dump("dump0");
    trigger = 1'b0;
    wait_bytes("dump0_first", 1);
    chk("dump0_first_byte", (got.size() > 0) ? got[0] : 8'hxx, 8'hA5);
    wait_bytes("dump0_mid", 6);
    hold_busy = 1'b1;
    tick();
    n0 = got.size();
    repeat (100) tick();
    chk("stall_no_write", 64'(got.size()), 64'(n0));
    hold_busy = 1'b0;
    wait_done("dump0");
    repeat (20) tick();
    chk("dump0_done_once", 64'(done_cnt), 64'd1);
    check_dump("dump0");

    // All-ones data with an always-ready UART; trigger chatter during the dump is ignored.
    mode     = 1;
    busy_len = 0;
    start_dump("dump1");
    for (int i = 0; i < 100; i++) begin
      trigger = 1'($urandom_range(0, 1));
      tick();
    end
    trigger = 1'b0;
    wait_done("dump1");
    repeat (60) tick();
    chk("dump1_done_once", 64'(done_cnt), 64'd1);
    chk("dump1_checksum", (got.size() == 21) ? got[20] : 8'hxx, 8'hF0);
    check_dump("dump1");

    // Random buffer contents and random UART busy lengths.
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) mem[y][x] = $urandom();
    mode      = 2;
    rand_busy = 1'b1;
    start_dump("dump2");
    trigger = 1'b0;
    wait_done("dump2");
    repeat (10) tick();
    check_dump("dump2");
    rand_busy = 1'b0;

    // Reset in the middle of the data phase aborts cleanly and disarms.
    mode     = 0;
    busy_len = 3;
    start_dump("dump3");
    trigger = 1'b0;
    wait_bytes("dump3_data", 6);
    areset = 1'b1;
    tick();
    chk("abort_outputs", {uart_write, busy, done, read_x, read_y}, '0);
    areset  = 1'b0;
    trigger = 1'b1;
    got.delete();
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= busy;
    end
    chk("abort_no_restart", 64'(seen), 64'd0);
    chk("abort_no_bytes", 64'(got.size()), 64'd0);
    trigger = 1'b0;
    repeat (10) tick();
    start_dump("dump4");
    trigger = 1'b0;
    wait_done("dump4");
    repeat (10) tick();
    chk("dump4_done_once", 64'(done_cnt), 64'd1);
    check_dump("dump4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
